// File: rtl/eth_pkt_buf_pkg.sv
// Shared types and header layout for the Ethernet RX packet buffer writer.
package eth_pkt_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HDR,
    ST_HOLD,
    ST_DROP
  } state_t;

  localparam int unsigned HDR_ADDR      = 0;
  localparam int unsigned DATA_BASE     = 1;
  localparam int unsigned HDR_VALID_BIT = 31;
  localparam int unsigned HDR_OVF_BIT   = 30;
  localparam int unsigned HDR_ERR_BIT   = 29;
  localparam int unsigned HDR_CNT_MSB   = 15;
  localparam int unsigned HDR_CNT_LSB   = 0;

  function automatic logic [31:0] make_header(input logic ovf, input logic err,
                                              input logic [15:0] cnt);
    logic [31:0] h;
    h = '0;
    h[HDR_VALID_BIT]            = 1'b1;
    h[HDR_OVF_BIT]              = ovf;
    h[HDR_ERR_BIT]              = err;
    h[HDR_CNT_MSB:HDR_CNT_LSB]  = cnt;
    return h;
  endfunction

endpackage

// File: rtl/eth_byte_packer.sv
// Little-endian byte-to-word packer: holds lower lanes and presents the word
// as it would look with the current byte merged in at the active lane.
module eth_byte_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        restart,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [3:0]  be,
  output logic        last_lane
);

  logic [1:0]      idx;
  logic [1:0]      lane;
  logic [3:0][7:0] lanes;

  assign lane      = restart ? 2'd0 : idx;
  assign last_lane = (lane == 2'd3);

  // Lanes above the active one are zeroed; byteenable masks them anyway.
  always_comb begin
    word = '0;
    be   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (2'(i) < lane) begin
        word[8*i +: 8] = lanes[i];
        be[i]          = 1'b1;
      end else if (2'(i) == lane) begin
        word[8*i +: 8] = data;
        be[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      lanes <= '0;
    end else if (load) begin
      lanes[lane] <= data;
      idx         <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/eth_rx_pkt_ram_writer.sv
// Avalon-ST byte sink writing received packets into the dual-port packet RAM,
// data from word 1 upward, then a status header at word 0.
module eth_rx_pkt_ram_writer
  import eth_pkt_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_error,
  output logic              in_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              pkt_ready,
  input  logic              pkt_ack,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [ADDR_W-1:0] LAST_WORD = '1;
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DATA_BASE);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] ptr, wr_addr;
  logic [CNT_W-1:0]  byte_cnt;
  logic              ovf, err, mid_drop, mid_nxt;
  logic              accept;
  logic              load, restart, data_wr, hdr_wr, drop_inc, ptr_inc, set_ovf, latch_err;
  logic [31:0]       pk_word;
  logic [3:0]        pk_be;
  logic              pk_last;

  eth_byte_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .restart   (restart),
    .data      (in_data),
    .word      (pk_word),
    .be        (pk_be),
    .last_lane (pk_last)
  );

  assign in_ready       = (state != ST_HDR);
  assign accept         = in_valid & in_ready;
  assign avm_chipselect = avm_write;
  assign wr_addr        = restart ? BASE_ADDR : ptr;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    restart   = 1'b0;
    data_wr   = 1'b0;
    hdr_wr    = 1'b0;
    drop_inc  = 1'b0;
    ptr_inc   = 1'b0;
    set_ovf   = 1'b0;
    latch_err = 1'b0;
    mid_nxt   = mid_drop;

    unique case (state)
      ST_IDLE: begin
        if (accept && in_sop) begin
          restart = 1'b1;
          load    = 1'b1;
        end
      end
      ST_FILL: begin
        if (accept) begin
          if (in_sop) begin
            drop_inc = 1'b1;
            restart  = 1'b1;
            load     = 1'b1;
          end else if (!ovf) begin
            load = 1'b1;
          end else if (in_eop) begin
            latch_err = 1'b1;
            state_nxt = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        hdr_wr    = 1'b1;
        mid_nxt   = 1'b0;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (accept) begin
          if (in_sop) begin
            drop_inc = 1'b1;
            mid_nxt  = !in_eop;
          end else if (in_eop) begin
            mid_nxt = 1'b0;
          end
        end
        if (pkt_ack) state_nxt = mid_nxt ? ST_DROP : ST_IDLE;
      end
      ST_DROP: begin
        if (accept && in_eop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Storing a byte is shared by packet start (from IDLE or an abort) and FILL.
    if (load) begin
      data_wr = pk_last | in_eop;
      if (pk_last) begin
        if (wr_addr == LAST_WORD) set_ovf = 1'b1;
        else                      ptr_inc = 1'b1;
      end
      if (in_eop) begin
        latch_err = 1'b1;
        state_nxt = ST_HDR;
      end else begin
        state_nxt = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      ptr            <= BASE_ADDR;
      byte_cnt       <= '0;
      ovf            <= 1'b0;
      err            <= 1'b0;
      mid_drop       <= 1'b0;
      drop_count     <= '0;
      pkt_ready      <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
    end else begin
      state    <= state_nxt;
      mid_drop <= mid_nxt;

      if (restart) begin
        ptr      <= BASE_ADDR;
        byte_cnt <= CNT_W'(1);
        ovf      <= 1'b0;
      end else begin
        if (ptr_inc) ptr      <= ptr + 1'b1;
        if (load)    byte_cnt <= byte_cnt + 1'b1;
        if (set_ovf) ovf      <= 1'b1;
      end
      if (latch_err) err <= in_error;

      if (drop_inc && drop_count != '1) drop_count <= drop_count + 1'b1;

      pkt_ready <= (state == ST_HOLD) && !pkt_ack;

      avm_write <= data_wr | hdr_wr;
      if (hdr_wr) begin
        avm_address    <= ADDR_W'(HDR_ADDR);
        avm_byteenable <= 4'hF;
        avm_writedata  <= make_header(ovf, err, 16'(byte_cnt));
      end else if (data_wr) begin
        avm_address    <= wr_addr;
        avm_byteenable <= pk_be;
        avm_writedata  <= pk_word;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_pkt_ram_writer.sv
// Directed bench for eth_rx_pkt_ram_writer: expected RAM writes are queued by the
// stimulus and matched by a monitor whenever avm_write is seen.
module tb_eth_rx_pkt_ram_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid, in_sop, in_eop, in_error, in_ready;
  logic [7:0]  avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect, avm_write;
  logic [31:0] avm_writedata;
  logic        pkt_ready, pkt_ack;
  logic [15:0] drop_count;

  eth_rx_pkt_ram_writer #(.ADDR_W(8), .DATA_W(32), .CNT_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_error       (in_error),
    .in_ready       (in_ready),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .pkt_ready      (pkt_ready),
    .pkt_ack        (pkt_ack),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] mon_mask;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the head of the expected queue (enabled lanes only).
  always @(negedge clk) begin
    if (reset_n === 1'b1 && avm_write === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr=%0d be=%h data=0x%08h, expected no write",
                 avm_address, avm_byteenable, avm_writedata);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_mask = {{8{mon_e.be[3]}}, {8{mon_e.be[2]}}, {8{mon_e.be[1]}}, {8{mon_e.be[0]}}};
        if (avm_address !== mon_e.addr || avm_byteenable !== mon_e.be ||
            (avm_writedata & mon_mask) !== (mon_e.data & mon_mask) || avm_chipselect !== 1'b1) begin
          fails++;
          $display("FAIL ram_write: got addr=%0d be=%h data=0x%08h cs=%b, expected addr=%0d be=%h data=0x%08h cs=1",
                   avm_address, avm_byteenable, avm_writedata, avm_chipselect,
                   mon_e.addr, mon_e.be, mon_e.data);
        end
      end
    end
  end

  task automatic push_word(input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.be = b; e.data = d;
    exp_q.push_back(e);
  endtask

  // Data words for a packet whose byte i has value i[7:0], nbytes stored.
  task automatic push_data(input int nbytes);
    for (int w = 0; w * 4 < nbytes; w++) begin
      wr_t e;
      e.addr = 8'(w + 1);
      e.be   = '0;
      e.data = '0;
      for (int j = 0; j < 4; j++) begin
        if (w * 4 + j < nbytes) begin
          e.be[j]         = 1'b1;
          e.data[8*j +: 8] = 8'(w * 4 + j);
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic s, input logic e,
                       input logic er, input logic ak);
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_error = er; pkt_ack = ak;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0; pkt_ack = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic err_last);
    for (int i = 0; i < len; i++) begin
      drive(8'(i), i == 0, i == len - 1, err_last && (i == len - 1), 1'b0);
      @(negedge clk);
    end
    idle();
  endtask

  // Called at the negedge right after the eop edge.
  task automatic check_ready_timing(input string tag);
    check({tag, "_in_ready_hdr"}, in_ready, 1'b0);
    check({tag, "_ready_t1"}, pkt_ready, 1'b0);
    @(negedge clk);
    check({tag, "_ready_t2"}, pkt_ready, 1'b0);
    @(negedge clk);
    check({tag, "_ready_t3"}, pkt_ready, 1'b1);
  endtask

  task automatic ack_pkt(input string tag);
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
    check({tag, "_ack_clears_ready"}, pkt_ready, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_write", avm_write, 1'b0);
    check("rst_cs", avm_chipselect, 1'b0);
    check("rst_addr", avm_address, 8'd0);
    check("rst_ready", pkt_ready, 1'b0);
    check("rst_drop", drop_count, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Byte without sop in IDLE is ignored (monitor flags any write).
    drive(8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    @(negedge clk);

    // 64-byte packet.
    push_data(64);
    push_word(8'd0, 4'hF, 32'h8000_0040);
    send_pkt(64, 1'b0);
    check_ready_timing("p64");

    // Whole packet while held: dropped, no writes.
    send_pkt(10, 1'b0);
    @(negedge clk);
    check("hold_drop_cnt1", drop_count, 16'd1);
    check("hold_ready_kept", pkt_ready, 1'b1);

    // Ack while a dropped packet is mid-flight -> DROP until its eop.
    drive(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'h56, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("midack_ready", pkt_ready, 1'b0);
    check("midack_drop_cnt2", drop_count, 16'd2);
    drive(8'h57, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'h58, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    @(negedge clk);

    // 61-byte packet with error.
    push_data(61);
    push_word(8'd16, 4'b0001, 32'h0000_003C);
    exp_q.delete(exp_q.size() - 2);
    push_word(8'd0, 4'hF, 32'hA000_003D);
    send_pkt(61, 1'b1);
    check_ready_timing("p61");
    ack_pkt("p61");

    // 1100-byte packet overflows after word 255.
    push_data(1020);
    push_word(8'd0, 4'hF, 32'hC000_03FC);
    send_pkt(1100, 1'b0);
    check_ready_timing("p1100");
    ack_pkt("p1100");

    // Missing eop: sop + 4 bytes, then a new sop aborts and restarts at word 1.
    push_word(8'd1, 4'hF, 32'hA3A2_A1A0);
    for (int i = 0; i < 5; i++) begin
      drive(8'(8'hA0 + i), i == 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    push_data(8);
    push_word(8'd0, 4'hF, 32'h8000_0008);
    send_pkt(8, 1'b0);
    check("abort_drop_cnt3", drop_count, 16'd3);
    check_ready_timing("p8");
    ack_pkt("p8");

    // Reset in the middle of FILL.
    push_word(8'd1, 4'hF, 32'h0302_0100);
    for (int i = 0; i < 6; i++) begin
      drive(8'(i), i == 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    idle();
    reset_n = 1'b0;
    #1;
    check("midrst_write", avm_write, 1'b0);
    check("midrst_addr", avm_address, 8'd0);
    check("midrst_be", avm_byteenable, 4'h0);
    check("midrst_data", avm_writedata, 32'h0);
    check("midrst_drop", drop_count, 16'd0);
    check("midrst_ready", pkt_ready, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1'b1);
    repeat (6) @(negedge clk);
    check("postrst_ready", pkt_ready, 1'b0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
